// File: rtl/csr_counter_unit_pkg.sv
// Shared definitions for the machine counter engine: counter width,
// slot indices into the CSR read file, mcountinhibit bits and slice FSM states.
package csr_counter_unit_pkg;

    localparam int XLEN = 32;

    localparam int CNT_MCYCLE    = 0;
    localparam int CNT_MCYCLEH   = 1;
    localparam int CNT_MINSTRET  = 2;
    localparam int CNT_MINSTRETH = 3;
    localparam int CNT_SLOTS     = 4;

    localparam int INHIBIT_CY = 0;
    localparam int INHIBIT_IR = 2;

    typedef enum logic {
        CNT_IDLE  = 1'b0,
        CNT_CARRY = 1'b1
    } cnt_state_e;

endpackage

// File: rtl/csr_counter_unit_if.sv
// Bundle between the computational stage / CSR read file (master side) and
// the counter engine (slave side).
interface csr_counter_unit_if;
    import csr_counter_unit_pkg::*;

    logic                               RetireValid;
    logic [CNT_SLOTS-1:0]               SWWriteHit;
    logic [CNT_SLOTS-1:0][XLEN-1:0]     CurVal;
    logic [XLEN-1:0]                    CountInhibit;
    logic [CNT_SLOTS-1:0]               InternalWriteEn;
    logic [CNT_SLOTS-1:0][XLEN-1:0]     InternalWriteData;

    modport master (
        output RetireValid,
        output SWWriteHit,
        output CurVal,
        output CountInhibit,
        input  InternalWriteEn,
        input  InternalWriteData
    );

    modport slave (
        input  RetireValid,
        input  SWWriteHit,
        input  CurVal,
        input  CountInhibit,
        output InternalWriteEn,
        output InternalWriteData
    );

endinterface

// File: rtl/csr_counter_unit_slice.sv
// One lo/hi counter pair. The lo half increments directly; with a 32-bit XLEN a
// lo wrap is carried into the hi half one cycle later through CarryPend.
module csr_counter_slice
    import csr_counter_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            sw_hit_lo,
    input  logic            sw_hit_hi,
    input  logic [XLEN-1:0] cur_lo,
    input  logic [XLEN-1:0] cur_hi,
    output logic            we_lo,
    output logic [XLEN-1:0] wd_lo,
    output logic            we_hi,
    output logic [XLEN-1:0] wd_hi
);

    // A software write to lo wins over the increment and therefore also kills any carry.
    assign we_lo = reset & inc & ~sw_hit_lo;
    assign wd_lo = we_lo ? cur_lo + XLEN'(1) : '0;

    generate
        if (XLEN == 32) begin : g_hi
            cnt_state_e state;
            logic       carry_pend;
            logic       wrap;

            assign carry_pend = (state == CNT_CARRY);
            assign wrap       = we_lo & (cur_lo == '1);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    state <= CNT_IDLE;
                end else begin
                    case (state)
                        CNT_IDLE:  if (wrap) state <= CNT_CARRY;
                        CNT_CARRY: state <= CNT_IDLE;
                        default:   state <= CNT_IDLE;
                    endcase
                end
            end

            // The carry completes regardless of inhibit; a software hi write simply drops it.
            assign we_hi = reset & carry_pend & ~sw_hit_hi;
            assign wd_hi = we_hi ? cur_hi + XLEN'(1) : '0;
        end else begin : g_no_hi
            logic unused_hi;
            assign unused_hi = ^{clk, sw_hit_hi, cur_hi};
            assign we_hi     = 1'b0;
            assign wd_hi     = '0;
        end
    endgenerate

endmodule

// File: rtl/csr_counter_unit.sv
// Machine counter engine: derives the mcycle/minstret increment conditions and
// maps two counter slices onto the CSR read file's internal-write slots.
module csr_counter_unit
    import csr_counter_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    csr_counter_unit_if.slave bus
);

    logic                           inc_cy;
    logic                           inc_ir;
    logic [CNT_SLOTS-1:0]           we;
    logic [CNT_SLOTS-1:0][XLEN-1:0] wd;
    logic                           unused_inhibit;

    assign inc_cy = ~bus.CountInhibit[INHIBIT_CY];
    assign inc_ir = bus.RetireValid & ~bus.CountInhibit[INHIBIT_IR];

    // Only CY and IR are meaningful here; the remaining inhibit bits are ignored.
    assign unused_inhibit = ^{bus.CountInhibit[XLEN-1:INHIBIT_IR+1], bus.CountInhibit[INHIBIT_CY+1]};

    csr_counter_slice u_cycle (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc_cy),
        .sw_hit_lo (bus.SWWriteHit[CNT_MCYCLE]),
        .sw_hit_hi (bus.SWWriteHit[CNT_MCYCLEH]),
        .cur_lo    (bus.CurVal[CNT_MCYCLE]),
        .cur_hi    (bus.CurVal[CNT_MCYCLEH]),
        .we_lo     (we[CNT_MCYCLE]),
        .wd_lo     (wd[CNT_MCYCLE]),
        .we_hi     (we[CNT_MCYCLEH]),
        .wd_hi     (wd[CNT_MCYCLEH])
    );

    csr_counter_slice u_instret (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc_ir),
        .sw_hit_lo (bus.SWWriteHit[CNT_MINSTRET]),
        .sw_hit_hi (bus.SWWriteHit[CNT_MINSTRETH]),
        .cur_lo    (bus.CurVal[CNT_MINSTRET]),
        .cur_hi    (bus.CurVal[CNT_MINSTRETH]),
        .we_lo     (we[CNT_MINSTRET]),
        .wd_lo     (wd[CNT_MINSTRET]),
        .we_hi     (we[CNT_MINSTRETH]),
        .wd_hi     (wd[CNT_MINSTRETH])
    );

    assign bus.InternalWriteEn   = we;
    assign bus.InternalWriteData = wd;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit: a small CSR file register bank closes the
// loop so counters really advance, and each task checks hand-computed values.
module tb_csr_counter_unit;
    import csr_counter_unit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [CNT_SLOTS-1:0][XLEN-1:0] csr;
    logic [CNT_SLOTS-1:0][XLEN-1:0] sw_data;

    csr_counter_unit_if bus ();

    csr_counter_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.CurVal = csr;

    // CSR file stand-in: software writes take priority over internal writes.
    always @(posedge clk) begin
        for (int s = 0; s < CNT_SLOTS; s++) begin
            if (bus.SWWriteHit[s])
                csr[s] <= sw_data[s];
            else if (bus.InternalWriteEn[s])
                csr[s] <= bus.InternalWriteData[s];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        bus.RetireValid  = 1'b0;
        bus.CountInhibit = '0;
        bus.SWWriteHit   = 4'b1111;
        sw_data          = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.InternalWriteEn !== 4'b0000) begin
                failures++;
                $display("FAIL reset_en cycle %0d got=%b exp=0000", i, bus.InternalWriteEn);
            end
            checks++;
            if (bus.InternalWriteData !== '0) begin
                failures++;
                $display("FAIL reset_data cycle %0d got=%h exp=0", i, bus.InternalWriteData);
            end
        end
        reset          = 1'b1;
        bus.SWWriteHit = 4'b0000;
        #1;
        checks++;
        if (bus.InternalWriteEn !== 4'b0001) begin
            failures++;
            $display("FAIL release_en got=%b exp=0001", bus.InternalWriteEn);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (csr[CNT_MCYCLE] !== XLEN'(i)) begin
                failures++;
                $display("FAIL release_mcycle step %0d got=%h exp=%h", i, csr[CNT_MCYCLE], i);
            end
            tick();
        end
    endtask

    task automatic test_carry();
        bus.SWWriteHit          = 4'b0011;
        sw_data[CNT_MCYCLE]     = 32'hFFFF_FFFE;
        sw_data[CNT_MCYCLEH]    = 32'd5;
        tick();
        bus.SWWriteHit = 4'b0000;
        checks++;
        if (csr[CNT_MCYCLE] !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL carry_preload got=%h exp=fffffffe", csr[CNT_MCYCLE]);
        end
        tick();
        checks++;
        if (csr[CNT_MCYCLE] !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL carry_lo_max got=%h exp=ffffffff", csr[CNT_MCYCLE]);
        end
        tick();
        checks++;
        if (csr[CNT_MCYCLE] !== 32'h0 || csr[CNT_MCYCLEH] !== 32'd5) begin
            failures++;
            $display("FAIL carry_stale_hi lo=%h hi=%h exp lo=0 hi=5", csr[CNT_MCYCLE], csr[CNT_MCYCLEH]);
        end
        checks++;
        if (bus.InternalWriteEn !== 4'b0011 || bus.InternalWriteData[CNT_MCYCLEH] !== 32'd6) begin
            failures++;
            $display("FAIL carry_hi_write en=%b data=%h exp en=0011 data=6", bus.InternalWriteEn, bus.InternalWriteData[CNT_MCYCLEH]);
        end
        tick();
        checks++;
        if (csr[CNT_MCYCLE] !== 32'h1 || csr[CNT_MCYCLEH] !== 32'd6) begin
            failures++;
            $display("FAIL carry_hi_updated lo=%h hi=%h exp lo=1 hi=6", csr[CNT_MCYCLE], csr[CNT_MCYCLEH]);
        end
        checks++;
        if (bus.InternalWriteEn[CNT_MCYCLEH] !== 1'b0) begin
            failures++;
            $display("FAIL carry_once got=%b exp=0", bus.InternalWriteEn[CNT_MCYCLEH]);
        end
    endtask

    task automatic test_sw_priority();
        bus.RetireValid       = 1'b1;
        bus.SWWriteHit        = 4'b0100;
        sw_data[CNT_MINSTRET] = 32'd100;
        #1;
        checks++;
        if (bus.InternalWriteEn[CNT_MINSTRET] !== 1'b0) begin
            failures++;
            $display("FAIL sw_blocks_inc got=%b exp=0", bus.InternalWriteEn[CNT_MINSTRET]);
        end
        tick();
        bus.SWWriteHit = 4'b0000;
        checks++;
        if (csr[CNT_MINSTRET] !== 32'd100) begin
            failures++;
            $display("FAIL sw_minstret got=%0d exp=100", csr[CNT_MINSTRET]);
        end
        tick();
        bus.RetireValid = 1'b0;
        checks++;
        if (csr[CNT_MINSTRET] !== 32'd101) begin
            failures++;
            $display("FAIL sw_then_retire got=%0d exp=101", csr[CNT_MINSTRET]);
        end
        tick();
        checks++;
        if (csr[CNT_MINSTRET] !== 32'd101) begin
            failures++;
            $display("FAIL no_retire_hold got=%0d exp=101", csr[CNT_MINSTRET]);
        end
    endtask

    task automatic test_sw_hi_drops_carry();
        bus.SWWriteHit       = 4'b0011;
        sw_data[CNT_MCYCLE]  = 32'hFFFF_FFFF;
        sw_data[CNT_MCYCLEH] = 32'h10;
        tick();
        bus.SWWriteHit = 4'b0000;
        tick();
        bus.SWWriteHit       = 4'b0010;
        sw_data[CNT_MCYCLEH] = 32'h20;
        #1;
        checks++;
        if (bus.InternalWriteEn[CNT_MCYCLEH] !== 1'b0) begin
            failures++;
            $display("FAIL sw_hi_blocks_carry got=%b exp=0", bus.InternalWriteEn[CNT_MCYCLEH]);
        end
        tick();
        bus.SWWriteHit = 4'b0000;
        #1;
        checks++;
        if (csr[CNT_MCYCLEH] !== 32'h20 || bus.InternalWriteEn !== 4'b0001) begin
            failures++;
            $display("FAIL sw_hi_written hi=%h en=%b exp hi=20 en=0001", csr[CNT_MCYCLEH], bus.InternalWriteEn);
        end
        tick();
        checks++;
        if (csr[CNT_MCYCLEH] !== 32'h20) begin
            failures++;
            $display("FAIL sw_hi_hold got=%h exp=20", csr[CNT_MCYCLEH]);
        end
    endtask

    task automatic test_sw_lo_kills_carry();
        bus.SWWriteHit       = 4'b0011;
        sw_data[CNT_MCYCLE]  = 32'hFFFF_FFFF;
        sw_data[CNT_MCYCLEH] = 32'd7;
        tick();
        bus.SWWriteHit      = 4'b0001;
        sw_data[CNT_MCYCLE] = 32'h50;
        tick();
        bus.SWWriteHit = 4'b0000;
        #1;
        checks++;
        if (csr[CNT_MCYCLE] !== 32'h50 || bus.InternalWriteEn[CNT_MCYCLEH] !== 1'b0) begin
            failures++;
            $display("FAIL sw_lo_no_carry lo=%h en_hi=%b exp lo=50 en_hi=0", csr[CNT_MCYCLE], bus.InternalWriteEn[CNT_MCYCLEH]);
        end
        tick();
        checks++;
        if (csr[CNT_MCYCLEH] !== 32'd7 || csr[CNT_MCYCLE] !== 32'h51) begin
            failures++;
            $display("FAIL sw_lo_hi_hold hi=%h lo=%h exp hi=7 lo=51", csr[CNT_MCYCLEH], csr[CNT_MCYCLE]);
        end
    endtask

    task automatic test_inhibit();
        bus.CountInhibit      = 32'h5;
        bus.RetireValid       = 1'b1;
        bus.SWWriteHit        = 4'b0101;
        sw_data[CNT_MCYCLE]   = 32'h1000;
        sw_data[CNT_MINSTRET] = 32'h2000;
        tick();
        bus.SWWriteHit = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (csr[CNT_MCYCLE] !== 32'h1000 || csr[CNT_MINSTRET] !== 32'h2000 || bus.InternalWriteEn !== 4'b0000) begin
                failures++;
                $display("FAIL inhibit_frozen %0d cy=%h ir=%h en=%b exp cy=1000 ir=2000 en=0000", i, csr[CNT_MCYCLE], csr[CNT_MINSTRET], bus.InternalWriteEn);
            end
        end
        bus.CountInhibit = '0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (csr[CNT_MCYCLE] !== 32'h1000 + XLEN'(i) || csr[CNT_MINSTRET] !== 32'h2000 + XLEN'(i)) begin
                failures++;
                $display("FAIL inhibit_resume %0d cy=%h ir=%h exp cy=%h ir=%h", i, csr[CNT_MCYCLE], csr[CNT_MINSTRET], 32'h1000 + i, 32'h2000 + i);
            end
        end
        bus.RetireValid = 1'b0;
    endtask

    task automatic test_reset_in_carry();
        bus.SWWriteHit       = 4'b0011;
        sw_data[CNT_MCYCLE]  = 32'hFFFF_FFFF;
        sw_data[CNT_MCYCLEH] = 32'd9;
        tick();
        bus.SWWriteHit = 4'b0000;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.InternalWriteEn !== 4'b0000 || bus.InternalWriteData !== '0) begin
            failures++;
            $display("FAIL carry_reset_outputs en=%b data=%h exp 0", bus.InternalWriteEn, bus.InternalWriteData);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (csr[CNT_MCYCLEH] !== 32'd9 || bus.InternalWriteEn !== 4'b0001) begin
            failures++;
            $display("FAIL carry_reset_dropped hi=%h en=%b exp hi=9 en=0001", csr[CNT_MCYCLEH], bus.InternalWriteEn);
        end
        tick();
        checks++;
        if (csr[CNT_MCYCLEH] !== 32'd9 || csr[CNT_MCYCLE] !== 32'h1) begin
            failures++;
            $display("FAIL carry_reset_after hi=%h lo=%h exp hi=9 lo=1", csr[CNT_MCYCLEH], csr[CNT_MCYCLE]);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        bus.RetireValid = 1'b0;
        bus.SWWriteHit  = '0;
        bus.CountInhibit = '0;
        sw_data         = '0;
        test_reset();
        test_carry();
        test_sw_priority();
        test_sw_hi_drops_carry();
        test_sw_lo_kills_carry();
        test_inhibit();
        test_reset_in_carry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
